// File: rtl/proc_pkg.sv
// Shared processor types for the fetch unit: FSM states, word/address types,
// queue entry layout and the sequential PC step.
package proc_pkg;

    typedef logic [31:0] instr_t;
    typedef logic [31:0] addr_t;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } ifu_state_e;

    typedef struct packed {
        instr_t instr;
        addr_t  pc;
    } ifu_entry_t;

    localparam addr_t PC_INCR = 32'd4;

    function automatic addr_t align_pc(input addr_t pc);
        return pc & ~addr_t'(32'h3);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with synchronous flush; head data reads as zero when empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is allowed only when the head leaves in the same cycle.
    assign do_pop    = pop && (count != '0);
    assign do_push   = push && ((count != (AW+1)'(DEPTH)) || do_pop);
    assign head_data = (count != '0) ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Credit-based instruction fetch unit with redirect/drain handling.
// Optional IFU_PERF_CNT_EN adds fetch and flush performance counters.
module instr_fetch_unit
    import proc_pkg::*;
#(
    parameter int    QUEUE_DEPTH = 4,
    parameter addr_t RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    ifu_state_e    state;
    ifu_state_e    state_next;
    addr_t         fetch_pc;
    logic [CW-1:0] discard_cnt;
    logic [CW-1:0] discard_next;
    logic [CW-1:0] q_count;
    logic [CW-1:0] f_count;
    logic [CW:0]   credit_used;
    ifu_entry_t    q_push_data;
    ifu_entry_t    q_head;
    addr_t         f_head;
    logic          req_fire;
    logic          rsp_keep;
    logic          q_pop;

    assign req_fire      = imem_req_valid && imem_req_ready;
    assign rsp_keep      = imem_rsp_valid && !redirect_valid && (state == RUN);
    assign q_pop         = instr_valid && instr_ready && !redirect_valid;
    assign credit_used   = {1'b0, q_count} + {1'b0, f_count};
    assign imem_req_addr = fetch_pc;
    assign instr_valid   = (q_count != '0);
    assign instr         = q_head.instr;
    assign instr_pc      = q_head.pc;
    assign q_push_data   = '{instr: imem_rsp_data, pc: f_head};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (redirect_valid) begin
            state_next = (discard_next != '0) ? DRAIN : RUN;
        end else if ((state == DRAIN) && imem_rsp_valid && (discard_cnt == CW'(1))) begin
            state_next = RUN;
        end
    end

    // Request only while every outstanding response is guaranteed a queue slot.
    always_comb begin
        imem_req_valid = 1'b0;
        if (reset_n && (state == RUN) && (credit_used < (CW+1)'(QUEUE_DEPTH))) begin
            imem_req_valid = 1'b1;
        end
    end

    // On redirect every response still owed by memory becomes a discard; in DRAIN the
    // in-flight FIFO is already empty, so its count only matters when leaving RUN.
    always_comb begin
        discard_next = discard_cnt;
        if (redirect_valid) begin
            discard_next = f_count + discard_cnt + CW'(req_fire) - CW'(imem_rsp_valid);
        end else if ((state == DRAIN) && imem_rsp_valid) begin
            discard_next = discard_cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc    <= RESET_PC;
            discard_cnt <= '0;
        end else begin
            discard_cnt <= discard_next;
            if (redirect_valid) begin
                fetch_pc <= align_pc(redirect_pc);
            end else if (req_fire) begin
                fetch_pc <= fetch_pc + PC_INCR;
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(ifu_entry_t)),
        .DEPTH (QUEUE_DEPTH)
    ) u_instr_queue (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (redirect_valid),
        .push      (rsp_keep),
        .push_data (q_push_data),
        .pop       (q_pop),
        .head_data (q_head),
        .count     (q_count)
    );

    sync_fifo #(
        .WIDTH ($bits(addr_t)),
        .DEPTH (QUEUE_DEPTH)
    ) u_inflight_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (redirect_valid),
        .push      (req_fire && !redirect_valid),
        .push_data (fetch_pc),
        .pop       (rsp_keep),
        .head_data (f_head),
        .count     (f_count)
    );

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (req_fire) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (redirect_valid) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed scenarios plus randomized traffic
// against a sequential-stream reference model and an in-order memory model.
module tb_instr_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .QUEUE_DEPTH (DEPTH),
        .RESET_PC    (RESET_PC)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
`ifdef IFU_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    exp_t        exp_q[$];
    exp_t        exp_head;
    logic [31:0] model_pc;
    logic [31:0] exp_req_pc;
    logic [31:0] pend[$];
    logic [31:0] req_log[$];
    logic [31:0] deliv_log[$];
    int          req_count   = 0;
    int          deliv_count = 0;
    int          req_cap     = 1 << 30;
    int          ready_prob  = 100;
    int          rsp_prob    = 100;
    bit          rsp_hold    = 1'b0;
    bit          found;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic missingEntry(input string name, input int idx, input logic [31:0] exp);
        checks++;
        errors++;
        $display("[TB] FAIL %s: entry %0d absent, required %h", name, idx, exp);
    endtask

    task automatic checkReq(input string name, input int idx, input logic [31:0] exp);
        if (idx < req_log.size()) checkOutput(name, req_log[idx], exp);
        else missingEntry(name, idx, exp);
    endtask

    task automatic checkDeliv(input string name, input int idx, input logic [31:0] exp);
        if (idx < deliv_log.size()) checkOutput(name, deliv_log[idx], exp);
        else missingEntry(name, idx, exp);
    endtask

    // Reference model: after reset or a redirect the delivered stream is simply
    // consecutive word addresses starting at the (word-aligned) target.
    function automatic void model_extend();
        exp_q.push_back('{pc: model_pc, data: mem_word(model_pc)});
        model_pc = model_pc + 32'd4;
    endfunction

    function automatic void model_restart(input logic [31:0] target);
        exp_q.delete();
        model_pc = {target[31:2], 2'b00};
        for (int i = 0; i < DEPTH; i++) model_extend();
    endfunction

    // In-order memory: answers the oldest accepted request, earliest one cycle later.
    initial begin
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            imem_req_ready = (req_count < req_cap) && ($urandom_range(99) < ready_prob);
            if (!reset_n) begin
                pend.delete();
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = '0;
            end else begin
                if (imem_rsp_valid && pend.size() > 0) void'(pend.pop_front());
                if (pend.size() > 0 && !rsp_hold && $urandom_range(99) < rsp_prob) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(pend[0]);
                end else begin
                    imem_rsp_valid = 1'b0;
                    imem_rsp_data  = '0;
                end
            end
        end
    end

    // Monitor: checks request addresses and scoreboard-pops on each delivered instruction.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (imem_req_valid && imem_req_ready) begin
                    checkOutput("req_addr", imem_req_addr, exp_req_pc);
                    pend.push_back(imem_req_addr);
                    exp_req_pc = exp_req_pc + 32'd4;
                    req_count++;
                    if (!redirect_valid) req_log.push_back(imem_req_addr);
                end
                if (redirect_valid) begin
                    exp_req_pc = {redirect_pc[31:2], 2'b00};
                end else if (instr_valid && instr_ready) begin
                    if (exp_q.size() == 0) model_extend();
                    exp_head = exp_q.pop_front();
                    checkOutput("instr_pc", instr_pc, exp_head.pc);
                    checkOutput("instr", instr, exp_head.data);
                    deliv_log.push_back(instr_pc);
                    deliv_count++;
                end
            end
        end
    end

    task automatic applyStimulus(input bit rv, input logic [31:0] rpc, input bit ir);
        @(posedge clk);
        #2;
        redirect_valid = rv;
        redirect_pc    = rpc;
        instr_ready    = ir;
        if (rv) begin
            model_restart(rpc);
            req_log.delete();
            deliv_log.delete();
        end
    endtask

    task automatic doReset();
        @(posedge clk);
        #2;
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        req_count      = 0;
        deliv_count    = 0;
        exp_req_pc     = RESET_PC;
        model_restart(RESET_PC);
        req_log.delete();
        deliv_log.delete();
        @(negedge clk);
        checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("rst_instr_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_instr", instr, 32'd0);
        checkOutput("rst_instr_pc", instr_pc, 32'd0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        exp_req_pc     = RESET_PC;
        model_restart(RESET_PC);

        // Startup: sequential fetch from RESET_PC, delivered in order.
        doReset();
        @(negedge clk);
        checkOutput("first_req_valid", 32'(imem_req_valid), 32'd1);
        repeat (12) applyStimulus(1'b0, '0, 1'b1);
        checkReq("startup_req0", 0, 32'h0);
        checkReq("startup_req3", 3, 32'hC);
        checkDeliv("startup_pc0", 0, 32'h0);
        checkDeliv("startup_pc1", 1, 32'h4);
        checkDeliv("startup_pc2", 2, 32'h8);
        checkDeliv("startup_pc3", 3, 32'hC);

        // Stalled consumer: exactly DEPTH requests, then the unit stops fetching.
        doReset();
        repeat (20) applyStimulus(1'b0, '0, 1'b0);
        checkOutput("stall_req_count", 32'(req_count), 32'(DEPTH));
        @(negedge clk);
        checkOutput("stall_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("stall_instr_valid", 32'(instr_valid), 32'd1);
        checkOutput("stall_head_pc", instr_pc, RESET_PC);
        checkOutput("stall_head_data", instr, mem_word(RESET_PC));
        repeat (10) applyStimulus(1'b0, '0, 1'b1);
        checkDeliv("stall_pc3", 3, 32'hC);

        // Redirect with two outstanding requests: both responses dropped.
        rsp_hold = 1'b1;
        req_cap  = 2;
        doReset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            applyStimulus(1'b0, '0, 1'b1);
            if (req_count == 2) found = 1'b1;
        end
        checkOutput("drain_setup", 32'(found), 32'd1);
        applyStimulus(1'b1, 32'h0000_0103, 1'b1);
        rsp_hold = 1'b0;
        req_cap  = 1 << 30;
        applyStimulus(1'b0, '0, 1'b1);
        @(negedge clk);
        checkOutput("drain_no_req", 32'(imem_req_valid), 32'd0);
        for (int i = 0; i < 20 && deliv_log.size() == 0; i++) applyStimulus(1'b0, '0, 1'b1);
        checkReq("drain_next_req", 0, 32'h0000_0100);
        checkDeliv("drain_first_pc", 0, 32'h0000_0100);

        // Address wrap at the top of memory.
        doReset();
        repeat (5) applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b1);
        for (int i = 0; i < 30 && req_log.size() < 3; i++) applyStimulus(1'b0, '0, 1'b1);
        checkReq("wrap_req0", 0, 32'hFFFF_FFF8);
        checkReq("wrap_req1", 1, 32'hFFFF_FFFC);
        checkReq("wrap_req2", 2, 32'h0000_0000);
        repeat (10) applyStimulus(1'b0, '0, 1'b1);
        checkDeliv("wrap_deliv2", 2, 32'h0000_0000);

        // Redirect, pop and response all in the same cycle.
        rsp_prob = 60;
        doReset();
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            applyStimulus(1'b0, '0, 1'($urandom_range(1)));
            if (imem_rsp_valid && instr_valid) begin
                found          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = 32'h0000_0200;
                instr_ready    = 1'b1;
                model_restart(32'h0000_0200);
                req_log.delete();
                deliv_log.delete();
            end
        end
        checkOutput("collide_setup", 32'(found), 32'd1);
        applyStimulus(1'b0, '0, 1'b1);
        @(negedge clk);
        checkOutput("collide_no_stale", 32'(instr_valid), 32'd0);
        repeat (20) applyStimulus(1'b0, '0, 1'b1);
        checkDeliv("collide_first_pc", 0, 32'h0000_0200);

`ifdef IFU_PERF_CNT_EN
        // Counters: ten accepted fetches and two redirects.
        rsp_prob = 100;
        req_cap  = 10;
        doReset();
        repeat (5) applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b1, 32'h0000_0040, 1'b1);
        repeat (5) applyStimulus(1'b0, '0, 1'b1);
        applyStimulus(1'b1, 32'h0000_0080, 1'b1);
        repeat (30) applyStimulus(1'b0, '0, 1'b1);
        checkOutput("perf_fetch_cnt", perf_fetch_cnt, 32'd10);
        checkOutput("perf_flush_cnt", perf_flush_cnt, 32'd2);
        req_cap = 1 << 30;
`endif

        // Randomized traffic with a reset in the middle of operation.
        ready_prob = 80;
        rsp_prob   = 70;
        doReset();
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) doReset();
            applyStimulus(1'($urandom_range(99) < 4), $urandom, 1'($urandom_range(99) < 70));
        end
        applyStimulus(1'b0, '0, 1'b1);
        checks++;
        if (deliv_count < 100) begin
            errors++;
            $display("[TB] FAIL random_progress: delivered %0d, required at least 100", deliv_count);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 4, instruction-queue entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port redirect_valid, input, 1, branch/jump redirect from the datapath.
REQ-006 SHALL have port redirect_pc, input, 32, redirect target.
REQ-007 SHALL have port imem_req_valid / imem_req_ready / imem_req_addr, output / input / output, 1/1/32, instruction-memory request handshake.
REQ-008 SHALL have port imem_rsp_valid / imem_rsp_data, input / input, 1/32, in-order memory response; always accepted.
REQ-009 SHALL have port instr_valid / instr_ready, output / input, 1/1, handshake to the datapath instruction input.
REQ-010 SHALL have port instr / instr_pc, output / output, 32/32, queue-head instruction and its address.

Function
REQ-011 SHALL issue a request when imem_req_valid && imem_req_ready, with addr = fetch PC; fetch PC then += 4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
REQ-012 SHALL assert imem_req_valid only in RUN and only when occupancy + outstanding < QUEUE_DEPTH (credit rule; no response is ever dropped for lack of space).
REQ-013 SHALL push each non-discarded response {data, pc} into the FIFO in issue order; the pc SHALL come from an internal in-flight address FIFO of the same depth.
REQ-014 SHALL drive instr_valid = queue non-empty; instr/instr_pc = head entry; pop on instr_valid && instr_ready.
REQ-015 SHALL, on redirect_valid, in the same edge: flush the queue, set fetch PC = {redirect_pc[31:2],2'b00}, load discard_cnt = outstanding (including any request issued that cycle), and enter DRAIN if discard_cnt>0, else RUN.
REQ-016 SHALL implement FSM states RUN and DRAIN; in DRAIN, no requests; each imem_rsp_valid decrements discard_cnt and is discarded; DRAIN->RUN when the last discarded response arrives.
REQ-017 SHALL give redirect priority: a same-cycle pop has no further effect; a same-cycle response is discarded and counted.
REQ-018 SHALL accept redirect in DRAIN: target replaced, discard_cnt keeps its value minus any same-cycle response.
REQ-019 SHALL have latency: response at edge N -> instr_valid high after edge N; first request issues in the first cycle after reset release.
REQ-020 SHALL, when the queue is full with zero outstanding, hold imem_req_valid low until a pop occurs.

Reset
REQ-021 SHALL, on reset_n low, asynchronously set fetch PC=RESET_PC, state=RUN, queue and in-flight FIFO empty, discard_cnt=0, imem_req_valid=0, instr_valid=0, instr=0, instr_pc=0.
REQ-022 SHALL, if reset asserts mid-operation, abandon outstanding responses; the memory is reset in the same domain.

Configuration
REQ-023 SHALL, with IFU_PERF_CNT_EN defined, add outputs perf_fetch_cnt[31:0] (accepted requests) and perf_flush_cnt[31:0] (redirects), both wrapping, reset to 0.
REQ-024 SHALL, without IFU_PERF_CNT_EN, omit those ports and their logic entirely.

Structure
REQ-025 SHALL place the IFU_STATE enum (RUN, DRAIN), the 32-bit instruction/address typedefs and the PC increment constant 4 in shared package proc_pkg.
REQ-026 SHALL instantiate one generic sub-module sync_fifo twice: instruction queue and in-flight address FIFO.

Verification
REQ-027 SHALL verify reset release, ready=1, 1-cycle memory: addresses 0x0,0x4,0x8,0xC issued; instr_ready=1 yields instr_pc in that order with matching data.
REQ-028 SHALL verify instr_ready=0 for 20 cycles: exactly 4 requests are issued, then imem_req_valid=0; 4 entries are held intact.
REQ-029 SHALL verify redirect to 0x0000_0103 with 2 outstanding: the next 2 responses are dropped, the next request is 0x100, and the first delivered instr_pc=0x100.
REQ-030 SHALL verify redirect to 0xFFFF_FFF8: fetch sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
REQ-031 SHALL verify same-cycle redirect + pop + response: queue empty next cycle, response counted as discarded, no stale instr_valid.
REQ-032 SHALL verify with IFU_PERF_CNT_EN: 10 accepted fetches and 2 redirects give perf_fetch_cnt=10 and perf_flush_cnt=2.
